load_store_unit: RTL and testbench

Memory-access stage of the processor pipeline, sitting directly upstream of the word-addressed data memory (512 × 32-bit, level-sensitive `active`/`rw` port, combinational read, read data 0 on write). It accepts load/store requests from execute with a valid/ready handshake and computes the byte address. It checks alignment and range, drives the memory port for exactly one cycle per access, and returns a registered response to writeback. Strictly one request in flight.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_addr_gen.sv | 35 +++
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Optional feature macro: LSU_BOUNDS_CHECK_EN (range-checks the word index).
package lsu_pkg;

    // FSM states: accept in IDLE, one memory cycle in ACCESS, hold response in RESP
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsuState_t;

    localparam int MEM_WORDS_DEFAULT = 512;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

endpackage : lsu_pkg

// File: rtl/lsu_addr_gen.sv
// Combinational address generation: byte address = base + offset (mod 2^32),
// word index, alignment fault and (with LSU_BOUNDS_CHECK_EN) range fault.
// Without LSU_BOUNDS_CHECK_EN the word index wraps modulo MEM_WORDS.
module lsu_addr_gen
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic [31:0] base,
    input  logic [31:0] offset,
    output logic [31:0] wordIndex,
    output logic        alignFault,
    output logic        rangeFault
);

    localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

    logic [31:0] addr;
    logic [31:0] wordRaw;

    // Byte address, raw word index and fault decode
    always_comb begin
        addr       = base + offset;
        wordRaw    = {2'b00, addr[31:2]};
        alignFault = (addr[1:0] != 2'b00);
`ifdef LSU_BOUNDS_CHECK_EN
        wordIndex  = wordRaw;
        rangeFault = (wordRaw >= MEM_WORDS_U);
`else
        wordIndex  = wordRaw % MEM_WORDS_U;
        rangeFault = 1'b0;
`endif
    end

endmodule : lsu_addr_gen

// File: rtl/load_store_unit.sv
// Memory-access pipeline stage: accepts one load/store at a time, performs a
// single-cycle access on a level-sensitive memory port, returns a registered
// response. Optional feature macro: LSU_BOUNDS_CHECK_EN (see lsu_addr_gen).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and its payload stable until that edge;
// ready never depends combinationally on valid (both ready/valid outputs here
// are decoded from the registered state only).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int TAG_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic             reqRw,
    input  logic [31:0]      reqBase,
    input  logic [31:0]      reqOffset,
    input  logic [31:0]      reqWdata,
    input  logic [TAG_W-1:0] reqRd,
    output logic             respValid,
    input  logic             respReady,
    output logic [31:0]      respData,
    output logic [TAG_W-1:0] respRd,
    output logic             respRw,
    output logic             respFault,
    output logic             memActive,
    output logic             memRw,
    output logic [31:0]      memIndex,
    output logic [31:0]      memWdata,
    input  logic [31:0]      memRdata,
    output lsuState_t        dbgState
);

    lsuState_t   state;
    logic [31:0] genIndex;
    logic        genAlignFault;
    logic        genRangeFault;
    logic        genFault;

    lsu_addr_gen #(
        .MEM_WORDS (MEM_WORDS)
    ) u_addr_gen (
        .base       (reqBase),
        .offset     (reqOffset),
        .wordIndex  (genIndex),
        .alignFault (genAlignFault),
        .rangeFault (genRangeFault)
    );

    // Either fault kind skips the memory cycle entirely
    always_comb begin
        genFault = genAlignFault | genRangeFault;
    end

    // Handshake flags and debug state are pure state decodes
    always_comb begin
        reqReady  = (state == IDLE);
        respValid = (state == RESP);
        dbgState  = state;
    end

    // FSM with registered memory-port and response outputs; the memory
    // port is nonzero only while in ACCESS so no stray level-write can occur
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            memActive <= 1'b0;
            memRw     <= 1'b0;
            memIndex  <= '0;
            memWdata  <= '0;
            respData  <= '0;
            respRd    <= '0;
            respRw    <= 1'b0;
            respFault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        respRw   <= reqRw;
                        respRd   <= reqRd;
                        respData <= '0;
                        if (genFault) begin
                            respFault <= 1'b1;
                            state     <= RESP;
                        end else begin
                            respFault <= 1'b0;
                            memActive <= 1'b1;
                            memRw     <= reqRw;
                            memIndex  <= genIndex;
                            memWdata  <= (reqRw == OP_STORE) ? reqWdata : 32'h0;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    respData  <= (memRw == OP_LOAD) ? memRdata : 32'h0;
                    memActive <= 1'b0;
                    memRw     <= 1'b0;
                    memIndex  <= '0;
                    memWdata  <= '0;
                    state     <= RESP;
                end
                RESP: begin
                    if (respReady) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : load_store_unit

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 512-word memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TAG_W = 5;

    logic             clk;
    logic             reset;
    logic             reqValid;
    logic             reqReady;
    logic             reqRw;
    logic [31:0]      reqBase;
    logic [31:0]      reqOffset;
    logic [31:0]      reqWdata;
    logic [TAG_W-1:0] reqRd;
    logic             respValid;
    logic             respReady;
    logic [31:0]      respData;
    logic [TAG_W-1:0] respRd;
    logic             respRw;
    logic             respFault;
    logic             memActive;
    logic             memRw;
    logic [31:0]      memIndex;
    logic [31:0]      memWdata;
    logic [31:0]      memRdata;
    lsuState_t        dbgState;

    logic [31:0] mem [512];
    int          memPulses;
    int          expPulses;
    int          vectors;
    int          miscompares;

    load_store_unit #(
        .MEM_WORDS (512),
        .TAG_W     (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqRw     (reqRw),
        .reqBase   (reqBase),
        .reqOffset (reqOffset),
        .reqWdata  (reqWdata),
        .reqRd     (reqRd),
        .respValid (respValid),
        .respReady (respReady),
        .respData  (respData),
        .respRd    (respRd),
        .respRw    (respRw),
        .respFault (respFault),
        .memActive (memActive),
        .memRw     (memRw),
        .memIndex  (memIndex),
        .memWdata  (memWdata),
        .memRdata  (memRdata),
        .dbgState  (dbgState)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: combinational read, 0 on write or idle
    assign memRdata = (memActive && !memRw) ? mem[memIndex[8:0]] : 32'h0;

    always @(posedge clk) begin
        if (memActive) memPulses <= memPulses + 1;
        if (memActive && memRw) mem[memIndex[8:0]] <= memWdata;
    end

    task automatic chkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkBit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive one request; returns in cycle 1 after acceptance
    task automatic sendReq(input logic rw, input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] wdata, input logic [TAG_W-1:0] rd);
        reqValid  = 1'b1;
        reqRw     = rw;
        reqBase   = base;
        reqOffset = off;
        reqWdata  = wdata;
        reqRd     = rd;
        step();
        reqValid  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        memPulses   = 0;
        expPulses   = 0;
        for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 + 32'(i);
        reset     = 1'b1;
        reqValid  = 1'b0;
        reqRw     = 1'b0;
        reqBase   = '0;
        reqOffset = '0;
        reqWdata  = '0;
        reqRd     = '0;
        respReady = 1'b1;
        step();
        step();

        // reset state
        chkBit ("rst_reqReady",  reqReady,  1'b1);
        chkBit ("rst_respValid", respValid, 1'b0);
        chkBit ("rst_memActive", memActive, 1'b0);
        chkWord("rst_memIndex",  memIndex,  32'h0);
        chkWord("rst_respData",  respData,  32'h0);
        chkWord("rst_state",     32'(dbgState), 32'(IDLE));
        reset = 1'b0;
        step();

        // store 0xDEADBEEF to 0x100+4 -> word 65
        sendReq(OP_STORE, 32'h100, 32'd4, 32'hDEAD_BEEF, 5'd3);
        expPulses++;
        chkBit ("st_memActive", memActive, 1'b1);
        chkBit ("st_memRw",     memRw,     1'b1);
        chkWord("st_memIndex",  memIndex,  32'd65);
        chkWord("st_memWdata",  memWdata,  32'hDEAD_BEEF);
        chkBit ("st_reqReady",  reqReady,  1'b0);
        chkBit ("st_respValid1", respValid, 1'b0);
        step();
        chkBit ("st_memActive2", memActive, 1'b0);
        chkBit ("st_respValid", respValid, 1'b1);
        chkWord("st_respData",  respData,  32'h0);
        chkBit ("st_respFault", respFault, 1'b0);
        chkBit ("st_respRw",    respRw,    1'b1);
        chkWord("st_respRd",    32'(respRd), 32'd3);
        step();
        chkBit ("st_idle_ready", reqReady, 1'b1);
        chkBit ("st_idle_valid", respValid, 1'b0);

        // load back the same address
        sendReq(OP_LOAD, 32'h100, 32'd4, 32'h1111_1111, 5'd7);
        expPulses++;
        chkBit ("ld_memActive", memActive, 1'b1);
        chkBit ("ld_memRw",     memRw,     1'b0);
        chkWord("ld_memIndex",  memIndex,  32'd65);
        chkWord("ld_memWdata",  memWdata,  32'h0);
        step();
        chkBit ("ld_respValid", respValid, 1'b1);
        chkWord("ld_respData",  respData,  32'hDEAD_BEEF);
        chkBit ("ld_respRw",    respRw,    1'b0);
        chkWord("ld_respRd",    32'(respRd), 32'd7);
        step();

        // misaligned load: 0x10+2
        sendReq(OP_LOAD, 32'h10, 32'd2, 32'h0, 5'd9);
        chkBit ("mis_respValid", respValid, 1'b1);
        chkBit ("mis_respFault", respFault, 1'b1);
        chkWord("mis_respData",  respData,  32'h0);
        chkBit ("mis_memActive", memActive, 1'b0);
        chkWord("mis_respRd",    32'(respRd), 32'd9);
        step();
        chkBit ("mis_reqReady",  reqReady,  1'b1);

        // negative offset: 0x20-8 -> word 6
        sendReq(OP_LOAD, 32'h20, 32'hFFFF_FFF8, 32'h0, 5'd1);
        expPulses++;
        chkBit ("neg_memActive", memActive, 1'b1);
        chkWord("neg_memIndex",  memIndex,  32'd6);
        step();
        chkBit ("neg_respFault", respFault, 1'b0);
        chkWord("neg_respData",  respData,  32'hA000_0006);
        step();

        // word index 512
        sendReq(OP_LOAD, 32'h800, 32'd0, 32'h0, 5'd2);
`ifdef LSU_BOUNDS_CHECK_EN
        chkBit ("rng_memActive", memActive, 1'b0);
        chkBit ("rng_respValid", respValid, 1'b1);
        chkBit ("rng_respFault", respFault, 1'b1);
        chkWord("rng_respData",  respData,  32'h0);
        step();
`else
        expPulses++;
        chkBit ("rng_memActive", memActive, 1'b1);
        chkWord("rng_memIndex",  memIndex,  32'd0);
        step();
        chkBit ("rng_respFault", respFault, 1'b0);
        chkWord("rng_respData",  respData,  32'hA000_0000);
        step();
`endif

        // back-pressure: hold respReady low five cycles with a pending request
        respReady = 1'b0;
        sendReq(OP_LOAD, 32'h104, 32'd0, 32'h0, 5'd12);
        expPulses++;
        reqValid  = 1'b1;
        reqRw     = OP_STORE;
        reqBase   = 32'h40;
        reqOffset = 32'd0;
        reqWdata  = 32'h1234_5678;
        reqRd     = 5'd13;
        step();
        for (int i = 0; i < 5; i++) begin
            chkBit ("bp_respValid", respValid, 1'b1);
            chkWord("bp_respData",  respData,  32'hDEAD_BEEF);
            chkBit ("bp_reqReady",  reqReady,  1'b0);
            chkBit ("bp_memActive", memActive, 1'b0);
            step();
        end
        chkWord("bp_respRd", 32'(respRd), 32'd12);
        respReady = 1'b1;
        step();
        chkBit ("bp_after_ready",  reqReady,  1'b1);
        chkBit ("bp_after_valid",  respValid, 1'b0);
        chkBit ("bp_after_mem",    memActive, 1'b0);
        step();
        reqValid = 1'b0;
        expPulses++;
        chkBit ("bp_next_mem",   memActive, 1'b1);
        chkBit ("bp_next_rw",    memRw,     1'b1);
        chkWord("bp_next_index", memIndex,  32'd16);
        step();
        chkBit ("bp_next_respRw", respRw,   1'b1);
        chkWord("bp_next_respRd", 32'(respRd), 32'd13);
        step();
        chkWord("bp_mem16", mem[16], 32'h1234_5678);

        // reset while in ACCESS
        sendReq(OP_LOAD, 32'h20, 32'hFFFF_FFF8, 32'h0, 5'd4);
        expPulses++;
        chkWord("rs_state_access", 32'(dbgState), 32'(ACCESS));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chkWord("rs_state",     32'(dbgState), 32'(IDLE));
        chkBit ("rs_memActive", memActive, 1'b0);
        chkBit ("rs_respValid", respValid, 1'b0);
        chkBit ("rs_reqReady",  reqReady,  1'b1);
        step();
        chkBit ("rs_noresp",    respValid, 1'b0);
        step();
        chkBit ("rs_noresp2",   respValid, 1'b0);

        chkWord("mem_pulse_count", 32'(memPulses), 32'(expPulses));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_load_store_unit
